memory_write_arbiter: RTL and testbench

Shares the single memory_write write port between two requesters (port A: execute write stage; port B: secondary writer such as stack/task-switch sequencing). Grants one requester at a time, muxes its write parameters onto the memory_write interface, and tracks the in-flight transfer's TLB phases so it knows when memory_write is idle. Routes done and fault status back to the owning requester and drains cleanly on wr_reset. Sits between the requesters and memory_write, and taps the tlbwrite_* status signals.

---
 rtl/memory_write_arbiter_if.sv | 47 ++++
 rtl/memory_write_arbiter.sv | 161 ++++++++++++++++
 tb/tb_memory_write_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_write_arbiter_if.sv
// Signal bundle between the two write requesters, the arbiter, memory_write
// and the TLB status tap. The arbiter connects through the slave modport.
interface memory_write_arbiter_if;
  // Handshake: x_do is raised by a requester and held until x_done pulses
  // (one cycle) or a fault level appears; the owner's parameters must stay
  // stable meanwhile. write_do is the arbiter's request to memory_write and
  // stays high from grant until the final tlbwrite_done or a fault.
  logic        a_do, b_do;
  logic [1:0]  a_cpl, b_cpl;
  logic [31:0] a_address, b_address;
  logic [2:0]  a_length, b_length;
  logic        a_lock, b_lock;
  logic        a_rmw, b_rmw;
  logic [31:0] a_data, b_data;
  logic        a_done, b_done;
  logic        a_page_fault, b_page_fault;
  logic        a_ac_fault, b_ac_fault;
  logic        wr_reset;
  logic        write_do;
  logic [1:0]  write_cpl;
  logic [31:0] write_address;
  logic [2:0]  write_length;
  logic        write_lock, write_rmw;
  logic [31:0] write_data;
  logic        write_done, write_page_fault, write_ac_fault;
  logic        tlbwrite_done, tlbwrite_page_fault, tlbwrite_ac_fault;

  modport slave (
    input  a_do, b_do, a_cpl, b_cpl, a_address, b_address, a_length, b_length,
           a_lock, b_lock, a_rmw, b_rmw, a_data, b_data, wr_reset,
           write_done, write_page_fault, write_ac_fault,
           tlbwrite_done, tlbwrite_page_fault, tlbwrite_ac_fault,
    output a_done, b_done, a_page_fault, b_page_fault, a_ac_fault, b_ac_fault,
           write_do, write_cpl, write_address, write_length, write_lock,
           write_rmw, write_data
  );

  modport master (
    output a_do, b_do, a_cpl, b_cpl, a_address, b_address, a_length, b_length,
           a_lock, b_lock, a_rmw, b_rmw, a_data, b_data, wr_reset,
           write_done, write_page_fault, write_ac_fault,
           tlbwrite_done, tlbwrite_page_fault, tlbwrite_ac_fault,
    input  a_done, b_done, a_page_fault, b_page_fault, a_ac_fault, b_ac_fault,
           write_do, write_cpl, write_address, write_length, write_lock,
           write_rmw, write_data
  );
endinterface

// File: rtl/memory_write_arbiter.sv
// Two-requester arbiter for the memory_write port: grants, muxes parameters,
// follows TLB phases of the in-flight write and routes done/fault to the owner.
module memory_write_arbiter #(
  parameter bit PRIORITY_A = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  memory_write_arbiter_if.slave  bus,
  output logic [1:0]             dbg_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DRAIN = 2'd2, FAULT = 2'd3} state_t;
  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

  state_t     state, state_nx;
  logic       owner, owner_nx;
  logic       last_owner, last_owner_nx;
  logic       lock_hold, lock_hold_nx;
  logic [1:0] phases_left, phases_left_nx;

  logic        pick, pick_valid, grant, sel;
  logic        tlb_fault, last_phase, split;
  logic [4:0]  span;
  logic [1:0]  sel_cpl;
  logic [31:0] sel_address, sel_data;
  logic [2:0]  sel_length;
  logic        sel_lock, sel_rmw;
  logic        do_int, a_done_int, b_done_int;
  logic        a_pf_int, b_pf_int, a_ac_int, b_ac_int;

  // A held lock restricts eligibility to the requester that set it.
  always_comb begin
    pick       = OWN_A;
    pick_valid = 1'b0;
    if (lock_hold) begin
      pick       = last_owner;
      pick_valid = last_owner ? bus.b_do : bus.a_do;
    end else begin
      pick_valid = bus.a_do | bus.b_do;
      if (PRIORITY_A)
        pick = bus.a_do ? OWN_A : OWN_B;
      else if (bus.a_do && bus.b_do)
        pick = ~last_owner;
      else
        pick = bus.a_do ? OWN_A : OWN_B;
    end
  end

  assign grant = (state == IDLE) && !bus.wr_reset && pick_valid &&
                 !bus.write_page_fault && !bus.write_ac_fault;
  assign sel   = (state == IDLE) ? (grant ? pick : last_owner) : owner;

  assign sel_cpl     = sel ? bus.b_cpl     : bus.a_cpl;
  assign sel_address = sel ? bus.b_address : bus.a_address;
  assign sel_length  = sel ? bus.b_length  : bus.a_length;
  assign sel_lock    = sel ? bus.b_lock    : bus.a_lock;
  assign sel_rmw     = sel ? bus.b_rmw     : bus.a_rmw;
  assign sel_data    = sel ? bus.b_data    : bus.a_data;

  // A write crossing a 16-byte line takes two TLB phases.
  assign span       = {1'b0, sel_address[3:0]} + {2'b00, sel_length};
  assign split      = span > 5'd16;
  assign tlb_fault  = bus.tlbwrite_page_fault | bus.tlbwrite_ac_fault;
  assign last_phase = bus.tlbwrite_done && (phases_left == 2'd1);

  always_comb begin
    state_nx       = state;
    owner_nx       = owner;
    last_owner_nx  = last_owner;
    lock_hold_nx   = lock_hold;
    phases_left_nx = phases_left;
    do_int         = 1'b0;
    a_done_int     = 1'b0;
    b_done_int     = 1'b0;
    a_pf_int       = 1'b0;
    b_pf_int       = 1'b0;
    a_ac_int       = 1'b0;
    b_ac_int       = 1'b0;
    case (state)
      IDLE: begin
        if (grant) begin
          do_int         = 1'b1;
          owner_nx       = pick;
          phases_left_nx = split ? 2'd2 : 2'd1;
          state_nx       = ACTIVE;
        end
      end
      ACTIVE: begin
        do_int = 1'b1;
        if (tlb_fault) begin
          state_nx = FAULT;
        end else begin
          a_done_int = bus.write_done && (owner == OWN_A);
          b_done_int = bus.write_done && (owner == OWN_B);
          if (bus.tlbwrite_done) phases_left_nx = phases_left - 2'd1;
          if (last_phase) begin
            state_nx      = IDLE;
            last_owner_nx = owner;
            lock_hold_nx  = sel_lock;
          end else if (bus.wr_reset) begin
            do_int   = 1'b0;
            state_nx = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (tlb_fault || phases_left == 2'd0) begin
          phases_left_nx = 2'd0;
          state_nx       = IDLE;
        end else if (bus.tlbwrite_done) begin
          phases_left_nx = phases_left - 2'd1;
          if (phases_left == 2'd1) state_nx = IDLE;
        end
      end
      FAULT: begin
        a_pf_int = (owner == OWN_A) && bus.write_page_fault;
        b_pf_int = (owner == OWN_B) && bus.write_page_fault;
        a_ac_int = (owner == OWN_A) && bus.write_ac_fault;
        b_ac_int = (owner == OWN_B) && bus.write_ac_fault;
        if (bus.wr_reset) begin
          state_nx       = IDLE;
          phases_left_nx = 2'd0;
          lock_hold_nx   = 1'b0;
        end
      end
    endcase
    if (bus.wr_reset) lock_hold_nx = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= OWN_A;
      last_owner  <= OWN_B;
      phases_left <= 2'd0;
      lock_hold   <= 1'b0;
    end else begin
      state       <= state_nx;
      owner       <= owner_nx;
      last_owner  <= last_owner_nx;
      phases_left <= phases_left_nx;
      lock_hold   <= lock_hold_nx;
    end
  end

  // Every output is forced low while reset is asserted.
  assign bus.write_do      = rst_n & do_int;
  assign bus.write_cpl     = rst_n ? sel_cpl     : 2'd0;
  assign bus.write_address = rst_n ? sel_address : 32'd0;
  assign bus.write_length  = rst_n ? sel_length  : 3'd0;
  assign bus.write_lock    = rst_n & sel_lock;
  assign bus.write_rmw     = rst_n & sel_rmw;
  assign bus.write_data    = rst_n ? sel_data    : 32'd0;
  assign bus.a_done        = rst_n & a_done_int;
  assign bus.b_done        = rst_n & b_done_int;
  assign bus.a_page_fault  = rst_n & a_pf_int;
  assign bus.b_page_fault  = rst_n & b_pf_int;
  assign bus.a_ac_fault    = rst_n & a_ac_int;
  assign bus.b_ac_fault    = rst_n & b_ac_int;
  assign dbg_state         = state;
endmodule

// File: tb/tb_memory_write_arbiter.sv
// Directed bench for memory_write_arbiter (round-robin build): grant, split,
// fault, drain, lock and flush scenarios with hand-computed expectations.
module tb_memory_write_arbiter;
  localparam logic [31:0] A_DATA  = 32'hA5A5_0001;
  localparam logic [31:0] B_DATA  = 32'h5B5B_0002;
  localparam logic [31:0] B_DATA2 = 32'hB0B0_0003;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         num_checks = 0;
  int         num_bad    = 0;

  memory_write_arbiter_if bus ();

  memory_write_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // driver tasks
  task automatic clear_inputs();
    bus.a_do = 0; bus.b_do = 0; bus.a_cpl = 0; bus.b_cpl = 0;
    bus.a_address = 0; bus.b_address = 0; bus.a_length = 0; bus.b_length = 0;
    bus.a_lock = 0; bus.b_lock = 0; bus.a_rmw = 0; bus.b_rmw = 0;
    bus.a_data = 0; bus.b_data = 0; bus.wr_reset = 0;
    bus.write_done = 0; bus.write_page_fault = 0; bus.write_ac_fault = 0;
    bus.tlbwrite_done = 0; bus.tlbwrite_page_fault = 0; bus.tlbwrite_ac_fault = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic req_a(input logic [31:0] addr, input logic [2:0] len, input logic lock);
    bus.a_do = 1; bus.a_address = addr; bus.a_length = len; bus.a_lock = lock; bus.a_data = A_DATA;
  endtask

  task automatic req_b(input logic [31:0] addr, input logic [2:0] len, input logic [31:0] data);
    bus.b_do = 1; bus.b_address = addr; bus.b_length = len; bus.b_data = data;
  endtask

  task automatic mem_status(input logic tlb_done, input logic wr_done);
    bus.tlbwrite_done = tlb_done; bus.write_done = wr_done;
  endtask

  initial begin
    // reset: outputs low even with a request present
    clear_inputs();
    rst_n = 1'b0;
    bus.a_do = 1; bus.a_data = A_DATA;
    next_cycle(); next_cycle();
    sample();
    check("rst_write_do", bus.write_do, 0);
    check("rst_write_data", bus.write_data, 0);
    check("rst_state", dbg_state, 0);
    check("rst_a_done", bus.a_done, 0);
    next_cycle();

    // single-phase A write, done at cycle 3
    do_reset();
    req_a(32'h1000, 3'd4, 0); bus.a_cpl = 2'd3;
    sample();
    check("t1_grant_do", bus.write_do, 1);
    check("t1_grant_addr", bus.write_address, 32'h1000);
    check("t1_grant_data", bus.write_data, A_DATA);
    check("t1_grant_cpl", bus.write_cpl, 3);
    next_cycle();
    sample();
    check("t1_active_state", dbg_state, 1);
    check("t1_active_do", bus.write_do, 1);
    check("t1_no_early_done", bus.a_done, 0);
    next_cycle(); next_cycle();
    mem_status(1, 1);
    sample();
    check("t1_a_done", bus.a_done, 1);
    check("t1_b_done", bus.b_done, 0);
    next_cycle();
    mem_status(0, 0); bus.a_do = 0;
    sample();
    check("t1_idle_state", dbg_state, 0);
    check("t1_idle_do", bus.write_do, 0);
    check("t1_idle_a_done", bus.a_done, 0);
    next_cycle();

    // round robin from reset: A, B, A
    do_reset();
    req_a(32'h2000, 3'd1, 0);
    req_b(32'h3000, 3'd2, B_DATA);
    sample();
    check("rr1_data", bus.write_data, A_DATA);
    check("rr1_do", bus.write_do, 1);
    next_cycle();
    mem_status(1, 1);
    sample();
    check("rr1_a_done", bus.a_done, 1);
    check("rr1_b_done", bus.b_done, 0);
    check("rr1_active_data", bus.write_data, A_DATA);
    next_cycle();
    mem_status(0, 0);
    sample();
    check("rr2_do", bus.write_do, 1);
    check("rr2_data", bus.write_data, B_DATA);
    check("rr2_addr", bus.write_address, 32'h3000);
    next_cycle();
    mem_status(1, 1);
    sample();
    check("rr2_b_done", bus.b_done, 1);
    check("rr2_a_done", bus.a_done, 0);
    check("rr2_active_data", bus.write_data, B_DATA);
    next_cycle();
    mem_status(0, 0);
    sample();
    check("rr3_data", bus.write_data, A_DATA);
    check("rr3_do", bus.write_do, 1);
    next_cycle();
    mem_status(1, 1);
    sample();
    check("rr3_a_done", bus.a_done, 1);
    next_cycle();
    clear_inputs();
    sample();
    check("rr_idle_do", bus.write_do, 0);
    next_cycle();

    // split transfer: 0xE + 4 = 18 bytes of span
    req_a(32'h100E, 3'd4, 0);
    sample();
    check("sp_grant_do", bus.write_do, 1);
    next_cycle();
    mem_status(1, 0);
    sample();
    check("sp_first_no_done", bus.a_done, 0);
    next_cycle();
    mem_status(1, 1);
    sample();
    check("sp_still_active", dbg_state, 1);
    check("sp_second_done", bus.a_done, 1);
    next_cycle();
    clear_inputs();
    sample();
    check("sp_idle", dbg_state, 0);
    next_cycle();

    // boundary: 0xC + 4 = 16 stays single-phase
    req_a(32'h100C, 3'd4, 0);
    next_cycle();
    mem_status(1, 1);
    sample();
    check("bd_done", bus.a_done, 1);
    next_cycle();
    clear_inputs();
    sample();
    check("bd_idle", dbg_state, 0);
    next_cycle();

    // B page fault, coincident done suppressed
    req_b(32'h4000, 3'd4, B_DATA2);
    sample();
    check("pf_grant_data", bus.write_data, B_DATA2);
    check("pf_grant_do", bus.write_do, 1);
    next_cycle();
    mem_status(1, 1); bus.tlbwrite_page_fault = 1; bus.write_page_fault = 1;
    sample();
    check("pf_no_b_done", bus.b_done, 0);
    check("pf_no_a_done", bus.a_done, 0);
    next_cycle();
    mem_status(0, 0); bus.tlbwrite_page_fault = 0;
    sample();
    check("pf_state", dbg_state, 3);
    check("pf_b_pf", bus.b_page_fault, 1);
    check("pf_a_pf", bus.a_page_fault, 0);
    check("pf_b_ac", bus.b_ac_fault, 0);
    check("pf_do", bus.write_do, 0);
    next_cycle();
    bus.write_page_fault = 0;
    sample();
    check("pf_follow_low", bus.b_page_fault, 0);
    next_cycle();
    bus.write_page_fault = 1; bus.wr_reset = 1;
    sample();
    check("pf_follow_high", bus.b_page_fault, 1);
    check("pf_hold_state", dbg_state, 3);
    next_cycle();
    clear_inputs();
    sample();
    check("pf_exit_idle", dbg_state, 0);
    check("pf_exit_b_pf", bus.b_page_fault, 0);
    next_cycle();

    // flush during first phase of a split A write, B waits for the drain
    req_a(32'h100E, 3'd4, 0);
    sample();
    check("dr_grant_do", bus.write_do, 1);
    next_cycle();
    bus.wr_reset = 1; req_b(32'h5000, 3'd2, B_DATA);
    sample();
    check("dr_flush_do", bus.write_do, 0);
    next_cycle();
    bus.wr_reset = 0; bus.a_do = 0; mem_status(1, 1);
    sample();
    check("dr_state", dbg_state, 2);
    check("dr_do1", bus.write_do, 0);
    check("dr_a_done1", bus.a_done, 0);
    check("dr_b_done1", bus.b_done, 0);
    next_cycle();
    sample();
    check("dr_do2", bus.write_do, 0);
    check("dr_a_done2", bus.a_done, 0);
    check("dr_b_done2", bus.b_done, 0);
    next_cycle();
    mem_status(0, 0);
    sample();
    check("dr_idle", dbg_state, 0);
    check("dr_b_grant_do", bus.write_do, 1);
    check("dr_b_grant_data", bus.write_data, B_DATA);
    next_cycle();
    mem_status(1, 1);
    sample();
    check("dr_b_done", bus.b_done, 1);
    next_cycle();
    clear_inputs();
    next_cycle();

    // locked A write keeps the port for A
    req_a(32'h6000, 3'd4, 1);
    sample();
    check("lk_grant_data", bus.write_data, A_DATA);
    next_cycle();
    req_b(32'h7000, 3'd4, B_DATA); mem_status(1, 1);
    sample();
    check("lk_a_done1", bus.a_done, 1);
    next_cycle();
    mem_status(0, 0); bus.a_lock = 0;
    sample();
    check("lk_a_again_do", bus.write_do, 1);
    check("lk_a_again_data", bus.write_data, A_DATA);
    next_cycle();
    mem_status(1, 1);
    sample();
    check("lk_a_done2", bus.a_done, 1);
    next_cycle();
    mem_status(0, 0);
    sample();
    check("lk_b_grant_data", bus.write_data, B_DATA);
    check("lk_b_grant_do", bus.write_do, 1);
    next_cycle();
    mem_status(1, 1);
    sample();
    check("lk_b_done", bus.b_done, 1);
    check("lk_b_done_a", bus.a_done, 0);
    next_cycle();
    clear_inputs();
    next_cycle();

    // lock released by flush; flush also blocks an IDLE grant
    req_a(32'h6000, 3'd4, 1);
    next_cycle();
    mem_status(1, 1);
    sample();
    check("lf_a_done", bus.a_done, 1);
    next_cycle();
    clear_inputs(); req_b(32'h7000, 3'd4, B_DATA);
    sample();
    check("lf_b_blocked", bus.write_do, 0);
    next_cycle();
    bus.wr_reset = 1;
    sample();
    check("lf_flush_no_grant", bus.write_do, 0);
    next_cycle();
    bus.wr_reset = 0;
    sample();
    check("lf_b_grant_do", bus.write_do, 1);
    check("lf_b_grant_data", bus.write_data, B_DATA);
    next_cycle();
    mem_status(1, 1);
    sample();
    check("lf_b_done", bus.b_done, 1);
    next_cycle();
    clear_inputs();
    next_cycle();

    // flush coincident with final tlbwrite_done still reports done
    req_a(32'h2000, 3'd2, 0);
    next_cycle();
    bus.wr_reset = 1; mem_status(1, 1);
    sample();
    check("fd_a_done", bus.a_done, 1);
    check("fd_do", bus.write_do, 1);
    next_cycle();
    clear_inputs();
    sample();
    check("fd_idle", dbg_state, 0);
    next_cycle();

    // final report
    $display("test done: total=%0d bad=%0d", num_checks, num_bad);
    $finish;
  end
endmodule
